// File: rtl/shift_pkg.sv
// Shared types for the sequential shifter: FSM states and shift-mode encodings.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Mode 2'b11 is reserved and behaves as logical.
  typedef enum logic [1:0] {
    MODE_LOG = 2'b00,
    MODE_ARI = 2'b01,
    MODE_ROT = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_step.sv
// Single 1-bit shift/rotate step: data, direction and mode in, next data out.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] step
);

  // One-position shift; left only distinguishes rotate, right distinguishes all modes.
  always_comb begin
    step = data;
    if (!dir) begin
      if (mode_e'(mode) == MODE_ROT) begin
        step = {data[WIDTH-2:0], data[WIDTH-1]};
      end else begin
        step = {data[WIDTH-2:0], 1'b0};
      end
    end else begin
      case (mode_e'(mode))
        MODE_ARI: step = {data[WIDTH-1], data[WIDTH-1:1]};
        MODE_ROT: step = {data[0], data[WIDTH-1:1]};
        default:  step = {1'b0, data[WIDTH-1:1]};
      endcase
    end
  end

endmodule

// File: rtl/shift_seq8.sv
// Sequential shifter: accepts a command in IDLE, applies one 1-bit step per
// cycle in SHIFT, then presents a registered result in DONE until taken.
module shift_seq8
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic [1:0]       mode_q;
  logic [SHW-1:0]   count_q;
  logic             zero_wait_q;
  logic [WIDTH-1:0] step_data;
  logic             accept;
  logic             take;

  assign accept = in_valid && (state_q == IDLE);
  assign take   = out_valid && out_ready && (state_q == DONE);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data (data_q),
    .dir  (dir_q),
    .mode (mode_q),
    .step (step_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (in_shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (count_q == SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (take) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
  end

  // Operand capture on accept, then one step and count decrement per SHIFT cycle.
  // A zero-amount command spends one extra cycle in DONE before loading the
  // output, so latency is max(shamt,1)+1 for every command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q      <= '0;
      dir_q       <= 1'b0;
      mode_q      <= MODE_LOG;
      count_q     <= '0;
      zero_wait_q <= 1'b0;
    end else begin
      zero_wait_q <= accept && (in_shamt == '0);
      if (accept) begin
        data_q  <= in_data;
        dir_q   <= in_dir;
        mode_q  <= in_mode;
        count_q <= in_shamt;
      end else if (state_q == SHIFT) begin
        data_q  <= step_data;
        count_q <= count_q - SHW'(1);
      end
    end
  end

  // Registered result: loaded once per DONE visit, held until the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (state_q == DONE) begin
      if (take) begin
        out_valid <= 1'b0;
      end else if (!out_valid && !zero_wait_q) begin
        out_valid <= 1'b1;
        out_data  <= data_q;
      end
    end
  end

endmodule

// File: tb/tb_shift_seq8.sv
// Directed bench for shift_seq8: hand-computed results, latency, backpressure,
// mid-operation reset and back-to-back commands.
module tb_shift_seq8;
  import shift_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_shamt;
  logic       in_dir;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int unsigned checks;
  int unsigned failures;

  shift_seq8 #(
    .WIDTH (8),
    .SHW   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_dir    (in_dir),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge after the accept edge; counts edges until out_valid.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) check("timeout", 32'd0, 32'd1);
  endtask

  // One command with out_ready high; in_* are scrambled after acceptance.
  task automatic run_cmd(input string tag, input logic [7:0] d, input logic [2:0] sh,
                         input logic dir, input logic [1:0] mode,
                         input logic [7:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_shamt = sh; in_dir = dir; in_mode = mode;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = ~d; in_shamt = ~sh; in_dir = ~dir; in_mode = ~mode;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(lat);
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_vld0"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy1"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic seen;
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_shamt = 3'd0;
    in_dir = 1'b0; in_mode = MODE_LOG; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    run_cmd("l3log", 8'hB4, 3'd3, 1'b0, MODE_LOG, 8'hA0, 4);
    run_cmd("r2ari", 8'hB4, 3'd2, 1'b1, MODE_ARI, 8'hED, 3);
    run_cmd("r2log", 8'hB4, 3'd2, 1'b1, MODE_LOG, 8'h2D, 3);
    run_cmd("r2rot", 8'hB4, 3'd2, 1'b1, MODE_ROT, 8'h2D, 3);
    run_cmd("l1rot", 8'h81, 3'd1, 1'b0, MODE_ROT, 8'h03, 2);
    run_cmd("sh0",   8'h5A, 3'd0, 1'b0, MODE_LOG, 8'h5A, 2);
    run_cmd("l7rsv", 8'hFF, 3'd7, 1'b0, MODE_RSV, 8'h80, 8);
    run_cmd("r7rsv", 8'h80, 3'd7, 1'b1, MODE_RSV, 8'h01, 8);
    run_cmd("r7ari", 8'h80, 3'd7, 1'b1, MODE_ARI, 8'hFF, 8);
    run_cmd("l5rot", 8'h21, 3'd5, 1'b0, MODE_ROT, 8'h24, 6);

    // Backpressure: result held for 5 cycles, then exactly one transfer.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h0F; in_shamt = 3'd2; in_dir = 1'b0; in_mode = MODE_ROT;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_data0", 32'(out_data), 32'h3C);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_vld", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h3C);
      check("bp_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_rel_vld", 32'(out_valid), 32'd0);
    check("bp_rel_rdy", 32'(in_ready), 32'd1);
    check("bp_rel_data", 32'(out_data), 32'h3C);

    // Reset in the second SHIFT cycle of a 7-step command.
    in_valid = 1'b1; in_data = 8'hFF; in_shamt = 3'd7; in_dir = 1'b1; in_mode = MODE_LOG;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_rdy", 32'(in_ready), 32'd1);
    check("mrst_vld", 32'(out_valid), 32'd0);
    check("mrst_data", 32'(out_data), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    check("mrst_quiet", 32'(seen), 32'd0);

    // Back-to-back with in_valid held; next operand presented during SHIFT.
    in_valid = 1'b1; in_data = 8'h3C; in_shamt = 3'd2; in_dir = 1'b0; in_mode = MODE_LOG;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'hC3; in_shamt = 3'd4; in_dir = 1'b1; in_mode = MODE_ARI;
    wait_valid(lat);
    check("b2b_a_data", 32'(out_data), 32'hF0);
    check("b2b_a_lat", 32'(lat), 32'd3);
    @(posedge clk);
    @(negedge clk);
    check("b2b_a_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00; in_shamt = 3'd1; in_dir = 1'b0; in_mode = MODE_ROT;
    check("b2b_b_busy", 32'(busy), 32'd1);
    wait_valid(lat);
    check("b2b_b_data", 32'(out_data), 32'hFC);
    check("b2b_b_lat", 32'(lat), 32'd5);
    @(posedge clk);
    @(negedge clk);
    check("b2b_end_vld", 32'(out_valid), 32'd0);
    check("b2b_end_rdy", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_seq8.md
SHIFT_SEQ8 -- requirements
Module: shift_seq8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter SHW, default 3, shift-amount width, equal to clog2(WIDTH).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  command present.
REQ-006 SHALL have port in_ready  output  1  block can accept a command.
REQ-007 SHALL have port in_data  input  WIDTH  operand.
REQ-008 SHALL have port in_shamt  input  SHW  shift amount, 0..WIDTH-1.
REQ-009 SHALL have port in_dir  input  1  0 = left, 1 = right.
REQ-010 SHALL have port in_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_data  output  WIDTH  shifted result.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement an FSM with the states IDLE, SHIFT and DONE.
REQ-016 SHALL assert in_ready only in IDLE; a command is accepted when in_valid and in_ready are both high on a clock edge.
REQ-017 On acceptance, the block SHALL register data, direction, mode and the remaining count (set to in_shamt); it SHALL go to SHIFT if in_shamt != 0, otherwise to DONE.
REQ-018 In SHIFT, each cycle SHALL apply one 1-bit step to the data register and decrement the count; when the count reaches 1, the next state SHALL be DONE.
REQ-019 Step semantics:
- left, any mode except rotate: shift in 0.
- left, rotate: MSB moves to the LSB.
- right, logical: shift in 0 at the MSB.
- right, arithmetic: replicate the MSB.
- right, rotate: LSB moves to the MSB.
REQ-020 Latency from acceptance to out_valid SHALL be max(in_shamt, 1) cycles plus 1 cycle (registered output); a shamt=0 command returns in_data unchanged.
REQ-021 In DONE, out_valid SHALL be 1 and out_data SHALL hold the result; both SHALL stay stable until out_ready=1.
REQ-022 After an out_valid and out_ready handshake, the block SHALL return to IDLE; in_ready SHALL rise in the following cycle (no same-cycle accept).
REQ-023 When out_valid=0, out_data SHALL be held at its last value; consumers SHALL not use it.
REQ-024 in_* inputs SHALL be ignored outside IDLE; changes to in_* during SHIFT SHALL not affect the result.
REQ-025 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-026 When rst_n=0 at a clock edge, the block SHALL enter IDLE with the count at 0, out_valid at 0, out_data at 0, busy at 0 and in_ready at 1 after the edge.
REQ-027 Reset mid-SHIFT or mid-DONE SHALL abort the operation; the pending result SHALL be discarded and never presented.
REQ-028 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-029 A shared package shift_pkg SHALL hold the state enum (IDLE/SHIFT/DONE) and the mode constants (MODE_LOG, MODE_ARI, MODE_ROT).
REQ-030 The single combinational sub-module shift_step SHALL implement the 1-bit step (data, dir, mode -> next data); the FSM and all registers SHALL live in shift_seq8.

Verification
REQ-031 Test: data=8'hB4, shamt=3, dir=L, mode=LOG, out_ready=1 -> out_data=8'hA0; out_valid rises 4 cycles after accept.
REQ-032 Test: data=8'hB4, shamt=2, dir=R, mode=ARI -> out_data=8'hED; with mode=LOG -> 8'h2D; with mode=ROT -> 8'h2D.
REQ-033 Test: data=8'h81, shamt=1, dir=L, mode=ROT -> 8'h03; then shamt=0 with data=8'h5A -> 8'h5A, with out_valid 2 cycles after accept.
REQ-034 Test: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stay stable and in_ready stays 0; release -> one transfer, then in_ready=1 the next cycle.
REQ-035 Test: pulse rst_n=0 in the 2nd SHIFT cycle of a shamt=7 command -> next cycle IDLE, out_valid=0, out_data=0, and no result ever appears.
REQ-036 Test: back-to-back commands with in_valid held high and in_data changed during SHIFT -> each result matches its accepted operand only.
